// File: rtl/m31_pkg.sv
// m31_pkg
// Shared definitions for the M31 (p = 2^31-1) Poseidon2 round datapath:
//   m31_t / P_M31     canonical field element type and modulus
//   round_mode_e      full round vs partial round selector
//   M4_COEF           4x4 external MDS block
//   m31_add_f         modular add of two canonical values
//   m31_mul_f         modular multiply with a single Mersenne fold
//   m31_rotl_f        multiply by 2^k, done as a 31-bit rotation

package m31_pkg;

  typedef logic [30:0] m31_t;

  localparam m31_t P_M31 = 31'h7FFF_FFFF;

  typedef enum logic {
    RM_FULL    = 1'b0,
    RM_PARTIAL = 1'b1
  } round_mode_e;

  localparam logic [2:0] M4_COEF [4][4] = '{
    '{3'd5, 3'd7, 3'd1, 3'd3},
    '{3'd4, 3'd6, 3'd1, 3'd1},
    '{3'd1, 3'd3, 3'd5, 3'd7},
    '{3'd1, 3'd1, 3'd4, 3'd6}
  };

  // Both operands are canonical, so the sum is below 2p and one
  // conditional subtract is enough to land back in [0, p).
  function automatic m31_t m31_add_f(input m31_t a, input m31_t b);
    logic [31:0] s;
    logic [31:0] d;
    s = {1'b0, a} + {1'b0, b};
    d = s - {1'b0, P_M31};
    return (s >= {1'b0, P_M31}) ? d[30:0] : s[30:0];
  endfunction

  // 2^31 == 1 mod p, so the 62-bit product folds as lo31 + hi31.
  // For canonical inputs that sum stays below 2p, so one conditional
  // subtract yields a canonical result.
  function automatic m31_t m31_mul_f(input m31_t a, input m31_t b);
    logic [61:0] prod;
    logic [31:0] s;
    logic [31:0] d;
    prod = 62'(a) * 62'(b);
    s    = {1'b0, prod[30:0]} + {1'b0, prod[61:31]};
    d    = s - {1'b0, P_M31};
    return (s >= {1'b0, P_M31}) ? d[30:0] : s[30:0];
  endfunction

  // x * 2^k mod p is a plain 31-bit left rotation. A canonical input is
  // never all ones, so the rotated value can never equal p either.
  function automatic m31_t m31_rotl_f(input m31_t x, input logic [4:0] k);
    logic [61:0] dbl;
    logic [5:0]  sh;
    dbl = {x, x};
    sh  = 6'd31 - {1'b0, k};
    dbl = dbl >> sh;
    return dbl[30:0];
  endfunction

endpackage

// File: rtl/m31_sbox_pipe.sv
// m31_sbox_pipe
// One lane of the round-constant add + x^5 S-box, SBOX_LAT stages deep.
//   clk, rst_n  clock, synchronous active-low reset
//   en          advance the pipeline (held when the round unit stalls)
//   bypass      pass a_i through unchanged (partial-round lanes 1..N-1)
//   a_i, b_i    state word and round constant, canonical
//   out_o       add(a,b)^5, or a_i when bypassed, SBOX_LAT cycles later

module m31_sbox_pipe
  import m31_pkg::*;
#(
  parameter int SBOX_LAT = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic bypass,
  input  m31_t a_i,
  input  m31_t b_i,
  output m31_t out_o
);

  m31_t a_sum;
  m31_t a1, sq1, a2, x4, r3;
  logic byp1, byp2;

  // Bypassed lanes skip the constant add and carry the raw state word.
  assign a_sum = bypass ? a_i : m31_add_f(a_i, b_i);

  // Stage 1 squares, stage 2 forms x^4, stage 3 multiplies back by x.
  // The base value travels alongside so stage 3 can select it on bypass.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a1   <= '0;
      sq1  <= '0;
      byp1 <= 1'b0;
      a2   <= '0;
      x4   <= '0;
      byp2 <= 1'b0;
      r3   <= '0;
    end else if (en) begin
      a1   <= a_sum;
      sq1  <= m31_mul_f(a_sum, a_sum);
      byp1 <= bypass;
      a2   <= a1;
      x4   <= m31_mul_f(sq1, sq1);
      byp2 <= byp1;
      r3   <= byp2 ? a2 : m31_mul_f(x4, a2);
    end
  end

  if (SBOX_LAT > 3) begin : g_extra
    m31_t dly [SBOX_LAT-3];

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        for (int i = 0; i < SBOX_LAT-3; i++) dly[i] <= '0;
      end else if (en) begin
        dly[0] <= r3;
        for (int i = 1; i < SBOX_LAT-3; i++) dly[i] <= dly[i-1];
      end
    end

    assign out_o = dly[SBOX_LAT-4];
  end else begin : g_none
    assign out_o = r3;
  end

endmodule

// File: rtl/m31_round_pipe.sv
// m31_round_pipe
// Stallable Poseidon2 round unit over M31. One round per accepted
// transaction, latency SBOX_LAT+1, one transaction per cycle.
//   clk, rst_n           clock, synchronous active-low reset
//   in_valid/in_ready    input handshake (in_ready is combinational)
//   in_mode              0 = full round, 1 = partial round
//   in_tag               sideband, returned on out_tag
//   state_i, const_i     WIDTH lanes of 31 bits, lane i at [31i+30:31i]
//   out_valid/out_ready  output handshake
//   out_tag, state_o     result tag and state
// WIDTH must be a multiple of 4 (>= 4); SBOX_LAT must be >= 3.

module m31_round_pipe
  import m31_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int SBOX_LAT = 3,
  parameter int TAG_W    = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_mode,
  input  logic [TAG_W-1:0]     in_tag,
  input  logic [WIDTH*31-1:0]  state_i,
  input  logic [WIDTH*31-1:0]  const_i,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [TAG_W-1:0]     out_tag,
  output logic [WIDTH*31-1:0]  state_o
);

  localparam int CHUNKS = WIDTH / 4;

  logic stall;
  logic en;

  logic [SBOX_LAT-1:0] v_pipe;
  logic [SBOX_LAT-1:0] m_pipe;
  logic [TAG_W-1:0]    tag_pipe [SBOX_LAT];

  m31_t        s_lane [WIDTH];
  m31_t        y      [WIDTH];
  m31_t        col    [4];
  m31_t        sum_all;
  m31_t        lin    [WIDTH];
  round_mode_e last_mode;

  // The whole pipeline, output register included, freezes while a
  // result is waiting downstream. in_ready is also forced high during
  // reset, since anything presented then is discarded anyway.
  assign stall    = out_valid && !out_ready;
  assign en       = !stall;
  assign in_ready = !rst_n || !stall;

  // Valid, mode and tag ride along with the S-box data. Bubbles stay as
  // bubbles; the pipeline never closes gaps.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v_pipe <= '0;
      m_pipe <= '0;
      for (int k = 0; k < SBOX_LAT; k++) tag_pipe[k] <= '0;
    end else if (en) begin
      v_pipe      <= {v_pipe[SBOX_LAT-2:0], in_valid};
      m_pipe      <= {m_pipe[SBOX_LAT-2:0], in_mode};
      tag_pipe[0] <= in_tag;
      for (int k = 1; k < SBOX_LAT; k++) tag_pipe[k] <= tag_pipe[k-1];
    end
  end

  // Lane 0 always goes through the S-box; the other lanes bypass it in
  // partial rounds.
  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    m31_sbox_pipe #(
      .SBOX_LAT (SBOX_LAT)
    ) u_sbox (
      .clk    (clk),
      .rst_n  (rst_n),
      .en     (en),
      .bypass ((i == 0) ? 1'b0 : in_mode),
      .a_i    (state_i[31*i +: 31]),
      .b_i    (const_i[31*i +: 31]),
      .out_o  (s_lane[i])
    );
  end

  assign last_mode = round_mode_e'(m_pipe[SBOX_LAT-1]);

  // Both linear layers are built every cycle; the mode that travelled
  // with the data picks one. Full: M4 per chunk, then each lane adds the
  // column sum of its position across chunks. Partial: total sum plus the
  // lane scaled by 2^(i mod 31).
  always_comb begin
    for (int i = 0; i < WIDTH; i++) begin
      y[i]   = '0;
      lin[i] = '0;
    end
    for (int k = 0; k < 4; k++) col[k] = '0;
    sum_all = '0;

    for (int j = 0; j < CHUNKS; j++) begin
      for (int r = 0; r < 4; r++) begin
        for (int c = 0; c < 4; c++) begin
          y[4*j+r] = m31_add_f(y[4*j+r],
                               m31_mul_f(31'(M4_COEF[r][c]), s_lane[4*j+c]));
        end
      end
    end

    for (int k = 0; k < 4; k++) begin
      for (int j = 0; j < CHUNKS; j++) col[k] = m31_add_f(col[k], y[4*j+k]);
    end

    for (int i = 0; i < WIDTH; i++) sum_all = m31_add_f(sum_all, s_lane[i]);

    for (int i = 0; i < WIDTH; i++) begin
      if (last_mode == RM_FULL) lin[i] = m31_add_f(y[i], col[i % 4]);
      else lin[i] = m31_add_f(sum_all, m31_rotl_f(s_lane[i], 5'(i % 31)));
    end
  end

  // Data only loads on a real result so state_o/out_tag keep the last
  // result across bubbles and read zero after reset until new data.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_tag   <= '0;
      state_o   <= '0;
    end else if (en) begin
      out_valid <= v_pipe[SBOX_LAT-1];
      if (v_pipe[SBOX_LAT-1]) begin
        out_tag <= tag_pipe[SBOX_LAT-1];
        for (int i = 0; i < WIDTH; i++) state_o[31*i +: 31] <= lin[i];
      end
    end
  end

endmodule

// File: tb/tb_m31_round_pipe.sv
// tb_m31_round_pipe
// Self-checking bench for m31_round_pipe with WIDTH=4, SBOX_LAT=3, TAG_W=8.
// Directed vectors with hand-computed results, plus a small modular
// reference model for mixed-mode and stall sequences.

module tb_m31_round_pipe;

  localparam int W   = 4;
  localparam int LAT = 3;
  localparam int TW  = 8;
  localparam int DW  = W * 31;
  localparam longint unsigned P = 64'h7FFF_FFFF;
  localparam int M4 [4][4] = '{'{5, 7, 1, 3}, '{4, 6, 1, 1},
                               '{1, 3, 5, 7}, '{1, 1, 4, 6}};

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic          in_mode;
  logic [TW-1:0] in_tag;
  logic [DW-1:0] state_i;
  logic [DW-1:0] const_i;
  logic          out_valid;
  logic          out_ready;
  logic [TW-1:0] out_tag;
  logic [DW-1:0] state_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  m31_round_pipe #(
    .WIDTH    (W),
    .SBOX_LAT (LAT),
    .TAG_W    (TW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_mode   (in_mode),
    .in_tag    (in_tag),
    .state_i   (state_i),
    .const_i   (const_i),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_tag   (out_tag),
    .state_o   (state_o)
  );

  // ---------------- reference model ----------------
  function automatic longint unsigned mAdd(input longint unsigned a, input longint unsigned b);
    return (a + b) % P;
  endfunction

  function automatic longint unsigned mMul(input longint unsigned a, input longint unsigned b);
    return (a * b) % P;
  endfunction

  function automatic longint unsigned mPow5(input longint unsigned a);
    longint unsigned r;
    r = 1;
    for (int n = 0; n < 5; n++) r = mMul(r, a);
    return r;
  endfunction

  function automatic logic [DW-1:0] refRound(input logic mode, input logic [DW-1:0] st,
                                             input logic [DW-1:0] cs);
    longint unsigned s [W];
    longint unsigned y [W];
    longint unsigned acc;
    longint unsigned o;
    logic [DW-1:0]   r;
    r = '0;
    for (int i = 0; i < W; i++) begin
      longint unsigned sv, cv;
      sv = 64'(st[31*i +: 31]);
      cv = 64'(cs[31*i +: 31]);
      s[i] = (!mode || i == 0) ? mPow5(mAdd(sv, cv)) : sv;
    end
    if (!mode) begin
      for (int i = 0; i < W; i++) begin
        y[i] = 0;
        for (int c = 0; c < 4; c++)
          y[i] = mAdd(y[i], mMul(64'(M4[i%4][c]), s[4*(i/4)+c]));
      end
      for (int i = 0; i < W; i++) begin
        acc = 0;
        for (int j = 0; j < W/4; j++) acc = mAdd(acc, y[4*j + i%4]);
        o = mAdd(y[i], acc);
        r[31*i +: 31] = 31'(o);
      end
    end else begin
      acc = 0;
      for (int i = 0; i < W; i++) acc = mAdd(acc, s[i]);
      for (int i = 0; i < W; i++) begin
        o = mAdd(acc, mMul(s[i], 64'(1) << (i % 31)));
        r[31*i +: 31] = 31'(o);
      end
    end
    return r;
  endfunction

  function automatic logic [DW-1:0] pack4(input longint unsigned a, input longint unsigned b,
                                          input longint unsigned c, input longint unsigned d);
    logic [DW-1:0] r;
    r = '0;
    r[30:0]  = 31'(a);
    r[61:31] = 31'(b);
    r[92:62] = 31'(c);
    r[123:93] = 31'(d);
    return r;
  endfunction

  function automatic logic [DW-1:0] mkState(input int k);
    logic [DW-1:0] r;
    r = '0;
    for (int l = 0; l < W; l++)
      r[31*l +: 31] = 31'((64'(k) * 1000003 + 64'(l) * 536870912 + 17) % P);
    return r;
  endfunction

  function automatic logic [DW-1:0] mkConst(input int k);
    logic [DW-1:0] r;
    r = '0;
    for (int l = 0; l < W; l++) r[31*l +: 31] = 31'(P - 1 - 64'(k) * 7 - 64'(l));
    return r;
  endfunction

  // ---------------- helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic m, input logic [TW-1:0] t,
                               input logic [DW-1:0] st, input logic [DW-1:0] cs);
    in_valid = v;
    in_mode  = m;
    in_tag   = t;
    state_i  = st;
    const_i  = cs;
  endtask

  // Single transaction on an idle pipe; checks exact latency of 4 edges.
  task automatic runOne(input string name, input logic m, input logic [TW-1:0] t,
                        input logic [DW-1:0] st, input logic [DW-1:0] cs,
                        input logic [DW-1:0] exp);
    out_ready = 1'b1;
    applyStimulus(1'b1, m, t, st, cs);
    tick();
    applyStimulus(1'b0, 1'b0, '0, '0, '0);
    tick();
    tick();
    checkOutput({name, "_early"}, 128'(out_valid), 128'd0);
    tick();
    checkOutput({name, "_valid"}, 128'(out_valid), 128'd1);
    checkOutput({name, "_data"}, 128'(state_o), 128'(exp));
    checkOutput({name, "_tag"}, 128'(out_tag), 128'(t));
    tick();
  endtask

  task automatic altTest();
    logic [DW-1:0] exp_a [8];
    logic [DW-1:0] st, cs;
    out_ready = 1'b1;
    for (int c = 0; c < 11; c++) begin
      if (c < 8) begin
        st = mkState(c);
        cs = mkConst(c);
        exp_a[c] = refRound(1'(c % 2), st, cs);
        applyStimulus(1'b1, 1'(c % 2), 8'(c), st, cs);
      end else begin
        applyStimulus(1'b0, 1'b0, '0, '0, '0);
      end
      tick();
      if (c >= 3) begin
        checkOutput($sformatf("alt%0d_valid", c-3), 128'(out_valid), 128'd1);
        checkOutput($sformatf("alt%0d_data", c-3), 128'(state_o), 128'(exp_a[c-3]));
        checkOutput($sformatf("alt%0d_tag", c-3), 128'(out_tag), 128'(c-3));
      end
    end
    tick();
    checkOutput("alt_drained", 128'(out_valid), 128'd0);
  endtask

  task automatic stallTest();
    logic [TW+DW-1:0] exp_q [$];
    logic [TW+DW-1:0] e;
    logic [DW-1:0]    st, cs, hold_d;
    logic [TW-1:0]    hold_t;
    logic             md, fire_in, fire_out;
    int  idx = 0, got = 0, stall_left = 0;
    bit  seen = 0, prev_stalled = 0;
    st = '0; cs = '0; md = 1'b0; hold_d = '0; hold_t = '0;
    for (int cyc = 0; cyc < 40 && got < 6; cyc++) begin
      if (idx < 6) begin
        st = mkState(idx + 20);
        cs = mkConst(idx + 20);
        md = (idx % 3 == 0);
        applyStimulus(1'b1, md, 8'(8'h10 + idx), st, cs);
      end else begin
        in_valid = 1'b0;
      end
      if (out_valid && !seen) begin
        seen = 1; stall_left = 2; out_ready = 1'b0;
      end else if (stall_left > 0) begin
        stall_left--; out_ready = 1'b0;
      end else begin
        out_ready = 1'b1;
      end
      #1;
      if (prev_stalled) begin
        checkOutput("stall_hold_valid", 128'(out_valid), 128'd1);
        checkOutput("stall_hold_data", 128'(state_o), 128'(hold_d));
        checkOutput("stall_hold_tag", 128'(out_tag), 128'(hold_t));
      end
      if (out_valid && !out_ready) begin
        checkOutput("stall_in_ready", 128'(in_ready), 128'd0);
        hold_d = state_o;
        hold_t = out_tag;
        prev_stalled = 1;
      end else begin
        prev_stalled = 0;
      end
      fire_in  = in_valid && in_ready;
      fire_out = out_valid && out_ready;
      if (fire_out) begin
        checkOutput("stall_no_extra", 128'(exp_q.size() > 0), 128'd1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          checkOutput($sformatf("stall%0d_data", got), 128'(state_o), 128'(e[DW-1:0]));
          checkOutput($sformatf("stall%0d_tag", got), 128'(out_tag), 128'(e[TW+DW-1:DW]));
        end
        got++;
      end
      if (fire_in) begin
        exp_q.push_back({8'(8'h10 + idx), refRound(md, st, cs)});
        idx++;
      end
      tick();
    end
    checkOutput("stall_count", 128'(got), 128'd6);
    checkOutput("stall_queue_empty", 128'(exp_q.size()), 128'd0);
    out_ready = 1'b1;
    in_valid  = 1'b0;
    tick();
    tick();
  endtask

  task automatic resetTest();
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b1, 1'(k % 2), 8'(8'h40 + k), mkState(k + 50), mkConst(k + 50));
      tick();
    end
    applyStimulus(1'b0, 1'b0, '0, '0, '0);
    out_ready = 1'b0;
    tick();
    rst_n = 1'b0;
    #1;
    checkOutput("rst_in_ready", 128'(in_ready), 128'd1);
    tick();
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      checkOutput($sformatf("rst_flush%0d_valid", k), 128'(out_valid), 128'd0);
      checkOutput($sformatf("rst_flush%0d_data", k), 128'(state_o), 128'd0);
      tick();
    end
    runOne("post_rst", 1'b0, 8'h77, pack4(0, 0, 0, 0), pack4(1, 0, 0, 0),
           pack4(10, 8, 2, 2));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst_n = 1'b0;
    out_ready = 1'b1;
    applyStimulus(1'b0, 1'b0, '0, '0, '0);
    tick();
    tick();
    checkOutput("reset_out_valid", 128'(out_valid), 128'd0);
    checkOutput("reset_state_o", 128'(state_o), 128'd0);
    checkOutput("reset_out_tag", 128'(out_tag), 128'd0);
    checkOutput("reset_in_ready", 128'(in_ready), 128'd1);
    rst_n = 1'b1;
    tick();

    runOne("full_c1", 1'b0, 8'hA5, pack4(0, 0, 0, 0), pack4(1, 0, 0, 0),
           pack4(10, 8, 2, 2));
    runOne("full_s2", 1'b0, 8'h3C, pack4(2, 0, 0, 0), pack4(0, 0, 0, 0),
           pack4(320, 256, 64, 64));
    runOne("full_wrap", 1'b0, 8'h5A, pack4(P - 1, 0, 0, 0), pack4(1, 0, 0, 0),
           pack4(0, 0, 0, 0));
    runOne("partial", 1'b1, 8'hC3, pack4(1, 1, 1, 1), pack4(0, 9, 9, 9),
           pack4(5, 6, 8, 12));

    altTest();
    stallTest();
    resetTest();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/m31_round_pipe.md
Name: m31_round_pipe

Overview:
- Parametrised, stallable Poseidon2 round unit over M31 (p = 2^31-1).
- Executes one round per accepted transaction: either a full round (all lanes through S-box, external MDS layer) or a partial round (lane 0 only through S-box, internal diagonal layer).
- Fully pipelined; one transaction per cycle.
- Valid/ready handshakes on input and output, with a tag carried alongside the data.
- Sits between the round-schedule controller and the state register file of the permutation core.

Parameters:
- WIDTH, 16, state lanes; must be a multiple of 4 and at least 4.
- SBOX_LAT, 3, pipeline stages in the add+x^5 path; must be at least 3.
- TAG_W, 8, width of the sideband tag.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous, active-low reset
- in_valid  in  1  input transaction valid
- in_ready  out  1  input accepted when in_valid && in_ready
- in_mode  in  1  0 = full round, 1 = partial round
- in_tag  in  TAG_W  sideband, returned unchanged
- state_i  in  WIDTH*31  lane i at bits [31i+30:31i], canonical (< p)
- const_i  in  WIDTH*31  round constants, canonical; in partial mode only lane 0 is used, other lanes are ignored
- out_valid  out  1  result valid
- out_ready  in  1  downstream ready
- out_tag  out  TAG_W  tag of the result
- state_o  out  WIDTH*31  result state, canonical

Behaviour:
- Reset (rst_n low at posedge):
  - All pipeline valid bits are cleared.
  - out_valid=0, state_o=0, out_tag=0.
  - Data registers are also cleared to 0.
  - Reset mid-operation discards all in-flight transactions; none reappear.
- Stall:
  - stall = out_valid && !out_ready.
  - in_ready = !stall; combinational, and 1 during and after reset.
  - While stalled, every pipeline register, including the output register, holds its value. Nothing is dropped or duplicated.
- Latency: L = SBOX_LAT+1 unstalled cycles from accept to out_valid. With out_ready held at 1, throughput is 1 transaction per cycle.
- Bubbles (in_valid=0) propagate as valid=0 and are not compressed.
- mode and tag travel in the pipeline with their data. Consecutive transactions may mix modes with no bubble.
- Field arithmetic:
  - add(a,b): s=a+b (32 bits); if s>=p then s-p.
  - mul: 62-bit product, folded as lo31+hi31, then one conditional subtract.
  - rotl31(x,k) = x*2^k mod p.
  - No output may ever equal p.
- Stages 1..SBOX_LAT:
  - a_i = add(state_i[i], const_i[i]).
  - Full mode: s_i = a_i^5 for every lane, computed as x2=a*a, x4=x2*x2, x5=x4*a.
  - Partial mode: s_0 = a_0^5; s_i = state_i[i] for i>0, delayed through the pipeline unchanged.
  - Extra stages beyond 3 are plain registers.
- Final stage: the linear layer is combinational and feeds the output register.
  - Full mode:
    - y = M4 applied to each 4-lane chunk, with M4 rows [5,7,1,3], [4,6,1,1], [1,3,5,7], [1,1,4,6].
    - c_k = sum over chunks of y[4j+k].
    - out_i = y_i + c_(i mod 4).
  - Partial mode:
    - sum = sum of all s_i.
    - out_i = sum + rotl31(s_i, i mod 31).
  - All sums are reduced mod p.

Decomposition:
- m31_pkg (shared):
  - m31_t (31-bit) typedef and P_M31 constant.
  - Functions m31_add_f, m31_mul_f, m31_rotl_f.
  - M4 coefficients.
  - round_mode_e enum (RM_FULL=0, RM_PARTIAL=1).
- Sub-module m31_sbox_pipe (parameter SBOX_LAT):
  - Ports: clk, rst_n, en (= !stall), bypass (partial lane pass-through), a_i, b_i, out_o.
  - One instance per lane.
- Linear layers are functions or generate blocks in the top module.

Test Plan:
- WIDTH=4, full, state={0,0,0,0}, const={1,0,0,0} -> after 4 cycles out={10,8,2,2}, tag echoed.
- WIDTH=4, full, state={2,0,0,0}, const=0 -> out={320,256,64,64}. Then state={p-1,0,0,0}, const={1,0,0,0} -> out={0,0,0,0} (wrap-around).
- WIDTH=4, partial, state={1,1,1,1}, const={0,9,9,9} -> out={5,6,8,12}; const lanes 1..3 are ignored.
- Alternate full/partial every cycle for 8 cycles with out_ready=1 -> 8 results in order on consecutive cycles, each matching a reference model, tags 0..7.
- Hold out_ready=0 once the first result is valid, keeping in_valid=1 -> in_ready=0 next cycle, state_o/out_tag stable. Release -> no loss or duplication, order preserved.
- Issue 3 transactions, assert rst_n=0 for 1 cycle mid-flight -> out_valid stays 0 until new input, state_o=0. A post-reset transaction appears after L cycles.
